// File: rtl/mxn_seq_shift_if.sv
// rtl/mxn_seq_shift_if.sv - request/result bus of the sequential lane shifter
//
// Purpose: groups the request (in_*) and result (out_*) handshakes plus the
//          busy flag of mxn_seq_shift into one bundle.
// Ports (signals):
//   in_valid, in_ready      request handshake
//   in_packed, shift_dir,   request payload (SETS lanes of WIDTH bits,
//   shift_amt               0=left / 1=right, unsigned distance)
//   out_valid, out_ready    result handshake
//   out_packed              shifted lanes, same packing as in_packed
//   busy                    operation in progress
// Modports: master = requester side, slave = shifter side.
interface mxn_seq_shift_if #(
  parameter int WIDTH = 4,
  parameter int SETS  = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [SETS*WIDTH-1:0] in_packed;
  logic                  shift_dir;
  logic [WIDTH-1:0]      shift_amt;
  logic                  out_valid;
  logic                  out_ready;
  logic [SETS*WIDTH-1:0] out_packed;
  logic                  busy;

  modport master (
    output in_valid, in_packed, shift_dir, shift_amt, out_ready,
    input  in_ready, out_valid, out_packed, busy
  );

  modport slave (
    input  in_valid, in_packed, shift_dir, shift_amt, out_ready,
    output in_ready, out_valid, out_packed, busy
  );
endinterface

// File: rtl/mxn_seq_shift.sv
// rtl/mxn_seq_shift.sv - multi-cycle per-lane shifter with valid/ready handshakes
//
// Purpose: shifts SETS independent WIDTH-bit lanes by min(shift_amt, WIDTH)
//          positions, one position per clock, and returns the result on a
//          valid/ready port. OP selects logical (0) or arithmetic (1) right shift.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mxn_seq_shift_if.slave (request, result, busy)
module mxn_seq_shift #(
  parameter int WIDTH = 4,
  parameter int SETS  = 2,
  parameter int OP    = 0
) (
  input logic            clk,
  input logic            rst_n,
  mxn_seq_shift_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Counter is one bit wider than shift_amt so it can hold WIDTH itself.
  localparam logic [WIDTH:0] CNT_MAX = WIDTH[WIDTH:0];
  localparam logic [WIDTH:0] CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [SETS*WIDTH-1:0] work_q, work_d;
  logic                  dir_q, dir_d;
  logic [WIDTH:0]        cnt_q, cnt_d;
  logic [WIDTH:0]        amt_ext;
  logic [WIDTH:0]        load_cnt;

  // One-position shift of every lane; lanes never exchange bits. Repeating
  // the current MSB on each arithmetic step keeps the original sign bit.
  function automatic logic [SETS*WIDTH-1:0] shift_once(
    input logic [SETS*WIDTH-1:0] w,
    input logic                  dir
  );
    logic [SETS*WIDTH-1:0] r;
    logic [WIDTH-1:0]      lane;
    logic                  fill;
    r = '0;
    for (int i = 0; i < SETS; i++) begin
      lane = w[i*WIDTH +: WIDTH];
      fill = (OP == 1) ? lane[WIDTH-1] : 1'b0;
      if (!dir) r[i*WIDTH +: WIDTH] = {lane[WIDTH-2:0], 1'b0};
      else      r[i*WIDTH +: WIDTH] = {fill, lane[WIDTH-1:1]};
    end
    return r;
  endfunction

  assign amt_ext  = {1'b0, bus.shift_amt};
  assign load_cnt = (amt_ext >= CNT_MAX) ? CNT_MAX : amt_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_packed;
          dir_d   = bus.shift_dir;
          cnt_d   = load_cnt;
          state_d = (load_cnt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = shift_once(work_q, dir_q);
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The working register keeps the last result after returning to IDLE,
  // until the next request overwrites it.
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_packed = work_q;
endmodule

// File: tb/tb_mxn_seq_shift.sv
// tb/tb_mxn_seq_shift.sv - bench for mxn_seq_shift, logical and arithmetic instances
module tb_mxn_seq_shift;
  localparam int W = 4;
  localparam int S = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mxn_seq_shift_if #(.WIDTH(W), .SETS(S)) bus0 ();
  mxn_seq_shift_if #(.WIDTH(W), .SETS(S)) bus1 ();

  mxn_seq_shift #(.WIDTH(W), .SETS(S), .OP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mxn_seq_shift #(.WIDTH(W), .SETS(S), .OP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each lane treated as a number; shift by min(amt, W).
  function automatic logic [S*W-1:0] model(input logic [S*W-1:0] v, input logic dir,
                                           input logic [W-1:0] amt, input int op);
    int n;
    int x;
    int r;
    logic [S*W-1:0] res;
    int mask;
    mask = (1 << W) - 1;
    n = (int'(amt) > W) ? W : int'(amt);
    res = '0;
    for (int i = 0; i < S; i++) begin
      x = int'(v >> (W * i)) & mask;
      if (!dir)                                r = (x << n) & mask;
      else if (op == 1 && x >= (1 << (W - 1))) r = ((x - (1 << W)) >>> n) & mask;
      else                                     r = x >> n;
      res = res | (S*W)'(r << (W * i));
    end
    return res;
  endfunction

  task automatic drive_in(input logic v, input logic [S*W-1:0] d, input logic dir,
                          input logic [W-1:0] amt);
    bus0.in_valid = v; bus0.in_packed = d; bus0.shift_dir = dir; bus0.shift_amt = amt;
    bus1.in_valid = v; bus1.in_packed = d; bus1.shift_dir = dir; bus1.shift_amt = amt;
  endtask

  task automatic set_ready(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  task automatic run_req(input logic [S*W-1:0] d, input logic dir, input logic [W-1:0] amt,
                         input int hold);
    int n;
    logic [S*W-1:0] e0, e1;
    n  = (int'(amt) > W) ? W : int'(amt);
    e0 = model(d, dir, amt, 0);
    e1 = model(d, dir, amt, 1);
    @(negedge clk);
    check("in_ready_idle", 32'({bus0.in_ready, bus1.in_ready}), 32'h3);
    drive_in(1'b1, d, dir, amt);
    set_ready(hold == 0);
    @(posedge clk);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k == 0) drive_in(1'b0, S*W'($urandom), 1'($urandom), W'($urandom));
      check("busy_run", 32'({bus0.busy, bus1.busy}), 32'h3);
      check("in_ready_run", 32'({bus0.in_ready, bus1.in_ready}), 32'h0);
      check("out_valid_lat", 32'({bus0.out_valid, bus1.out_valid}), (k == n) ? 32'h3 : 32'h0);
    end
    check("result_op0", 32'(bus0.out_packed), 32'(e0));
    check("result_op1", 32'(bus1.out_packed), 32'(e1));
    for (int h = 0; h < hold; h++) begin
      drive_in(1'b1, S*W'($urandom), 1'($urandom), W'($urandom));
      @(negedge clk);
      check("hold_valid", 32'({bus0.out_valid, bus1.out_valid}), 32'h3);
      check("hold_in_ready", 32'({bus0.in_ready, bus1.in_ready}), 32'h0);
      check("hold_op0", 32'(bus0.out_packed), 32'(e0));
      check("hold_op1", 32'(bus1.out_packed), 32'(e1));
    end
    drive_in(1'b0, d, dir, amt);
    set_ready(1'b1);
    @(negedge clk);
    check("post_valid", 32'({bus0.out_valid, bus1.out_valid}), 32'h0);
    check("post_in_ready", 32'({bus0.in_ready, bus1.in_ready}), 32'h3);
    check("post_busy", 32'({bus0.busy, bus1.busy}), 32'h0);
    check("post_keep_op0", 32'(bus0.out_packed), 32'(e0));
    check("post_keep_op1", 32'(bus1.out_packed), 32'(e1));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive_in(1'b0, '0, 1'b0, '0);
    set_ready(1'b0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'({bus0.in_ready, bus1.in_ready}), 32'h3);
    check("rst_out_valid", 32'({bus0.out_valid, bus1.out_valid}), 32'h0);
    check("rst_busy", 32'({bus0.busy, bus1.busy}), 32'h0);
    check("rst_out_packed", 32'({bus0.out_packed, bus1.out_packed}), 32'h0);
    rst_n = 1'b1;

    run_req(8'h93, 1'b0, 4'd1, 0);
    run_req(8'h9C, 1'b1, 4'd2, 0);
    run_req(8'h5A, 1'b0, 4'd0, 0);
    run_req(8'h5A, 1'b1, 4'd0, 0);
    run_req(8'h87, 1'b1, 4'd15, 0);
    run_req(8'h87, 1'b0, 4'd4, 0);
    run_req(8'hC3, 1'b1, 4'd1, 5);
    run_req(8'h6E, 1'b1, 4'd3, 0);

    // Abort: reset during the second SHIFT cycle of a 3-position request.
    @(negedge clk);
    drive_in(1'b1, 8'hB6, 1'b1, 4'd3);
    @(posedge clk);
    @(negedge clk);
    drive_in(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_in_ready", 32'({bus0.in_ready, bus1.in_ready}), 32'h3);
    check("abort_out_valid", 32'({bus0.out_valid, bus1.out_valid}), 32'h0);
    check("abort_busy", 32'({bus0.busy, bus1.busy}), 32'h0);
    check("abort_out_packed", 32'({bus0.out_packed, bus1.out_packed}), 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_result", 32'({bus0.out_valid, bus1.out_valid}), 32'h0);
    end

    for (int i = 0; i < 24; i++) begin
      run_req(S*W'($urandom), 1'($urandom), W'($urandom), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
